i2s_tx: RTL and testbench

- I2S master transmitter: the source end of the mic serial link.
- Divides the system clock to generate BCLK and LRCLK, and serializes buffered PCM samples MSB-first onto DOUT in standard Philips I2S framing.
- Used to drive the mic_translator input path in closed-loop bring-up, and as the audio output for an external DAC.
- Upstream producer writes samples over a valid/ready handshake into a one-entry holding buffer.

---
 rtl/i2s_tx.sv | 123 ++++++++++++
 tb/tb_i2s_tx.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/i2s_tx.sv
// i2s_tx: Philips I2S master transmitter with a one-entry sample buffer and clock divider.
// Define I2S_TX_RIGHT_DUP_EN to repeat each sample in the right slot; otherwise the right slot is zero.
`default_nettype none

module i2s_tx #(
   parameter int CLK_DIV  = 4,
   parameter int SLOT_W   = 32,
   parameter int SAMPLE_W = 18
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [SAMPLE_W-1:0] sample_data,
   input  logic                sample_valid,
   output logic                sample_ready,
   output logic                underrun,
   output logic                BCLK,
   output logic                LRCLK,
   output logic                DOUT
);

   localparam int D_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int K_W = $clog2(2 * SLOT_W);

   localparam logic [D_W-1:0] DIV_LAST = D_W'(CLK_DIV - 1);
   localparam logic [K_W-1:0] K_LAST   = K_W'(2 * SLOT_W - 1);
   localparam logic [K_W-1:0] K_SLOT   = K_W'(SLOT_W);
   localparam logic [K_W-1:0] J_SAMP   = K_W'(SAMPLE_W);

   logic [D_W-1:0]      div_cnt;
   logic [K_W-1:0]      k;
   logic [K_W-1:0]      k_next;
   logic [K_W-1:0]      k_next2;
   logic [K_W-1:0]      slot_j;
   logic [SAMPLE_W-1:0] shreg;
   logic [SAMPLE_W-1:0] buf_data;
   logic [SAMPLE_W-1:0] load_word;
   logic [SAMPLE_W-1:0] right_word;
   logic                buf_empty;
   logic                fall_evt;
   logic                wrap;
   logic                xfer;

   always_comb begin
      fall_evt  = (div_cnt == DIV_LAST) && BCLK;
      k_next    = (k == K_LAST) ? '0 : k + K_W'(1);
      k_next2   = (k_next == K_LAST) ? '0 : k_next + K_W'(1);
      slot_j    = (k_next < K_SLOT) ? k_next : k_next - K_SLOT;
      wrap      = fall_evt && (k_next == '0);
      load_word = buf_empty ? '0 : buf_data;
      xfer      = sample_valid && buf_empty;
   end

   assign sample_ready = buf_empty;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         div_cnt <= '0;
         BCLK    <= 1'b0;
      end else if (div_cnt == DIV_LAST) begin
         div_cnt <= '0;
         BCLK    <= ~BCLK;
      end else begin
         div_cnt <= div_cnt + D_W'(1);
      end
   end

   // A write coinciding with a frame load sees the pre-edge (empty) state, so the load underruns.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         buf_empty <= 1'b1;
         buf_data  <= '0;
         underrun  <= 1'b0;
      end else begin
         underrun <= wrap && buf_empty;
         if (xfer) begin
            buf_empty <= 1'b0;
            buf_data  <= sample_data;
         end else if (wrap) begin
            buf_empty <= 1'b1;
         end
      end
   end

`ifdef I2S_TX_RIGHT_DUP_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         right_word <= '0;
      end else if (wrap) begin
         right_word <= load_word;
      end
   end
`else
   assign right_word = '0;
`endif

   // LRCLK looks one bit ahead so it changes one BCLK before the slot's MSB.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         k     <= K_LAST;
         LRCLK <= 1'b0;
         DOUT  <= 1'b0;
         shreg <= '0;
      end else if (fall_evt) begin
         k     <= k_next;
         LRCLK <= (k_next2 >= K_SLOT);
         if (k_next == '0) begin
            DOUT  <= load_word[SAMPLE_W-1];
            shreg <= load_word << 1;
         end else if (k_next == K_SLOT) begin
            DOUT  <= right_word[SAMPLE_W-1];
            shreg <= right_word << 1;
         end else if (slot_j < J_SAMP) begin
            DOUT  <= shreg[SAMPLE_W-1];
            shreg <= shreg << 1;
         end else begin
            DOUT  <= 1'b0;
         end
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_i2s_tx.sv
// tb_i2s_tx: table-driven slot checks plus a cycle-level arithmetic reference model for i2s_tx.
`default_nettype none

module tb_i2s_tx;

   localparam int CD = 2;
   localparam int SW = 32;
   localparam int BW = 18;
   localparam int HP = 2 * CD;
   localparam int FR = 2 * SW;
`ifdef I2S_TX_RIGHT_DUP_EN
   localparam bit DUP = 1'b1;
`else
   localparam bit DUP = 1'b0;
`endif

   logic          clk;
   logic          rst_n;
   logic [BW-1:0] sample_data;
   logic          sample_valid;
   logic          sample_ready;
   logic          underrun;
   logic          BCLK;
   logic          LRCLK;
   logic          DOUT;

   i2s_tx #(.CLK_DIV(CD), .SLOT_W(SW), .SAMPLE_W(BW)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .sample_data  (sample_data),
      .sample_valid (sample_valid),
      .sample_ready (sample_ready),
      .underrun     (underrun),
      .BCLK         (BCLK),
      .LRCLK        (LRCLK),
      .DOUT         (DOUT)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;

   task automatic chk(input string name, input logic act, input logic req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%b required=%b t=%0t", name, act, req, $time);
      end
   endtask

   task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, act, req);
      end
   endtask

   // Reference model: time since reset release in clk edges, frame words by frame number.
   int            n = 0;
   bit            full = 0;
   bit            pre_full;
   logic [BW-1:0] bdata;
   logic [BW-1:0] words [0:255];
   logic [63:0]   cap   [0:255];
   bit            exp_ur = 0;
   int            xfer_cnt = 0;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         n      = 0;
         full   = 0;
         bdata  = '0;
         exp_ur = 0;
      end else begin
         pre_full = full;
         n        = n + 1;
         exp_ur   = 0;
         if ((n % HP) == 0 && (((n / HP) - 1) % FR) == 0) begin
            words[(((n / HP) - 1) / FR) % 256] = full ? bdata : '0;
            exp_ur = !full;
            full   = 0;
         end
         if (sample_valid && !pre_full) begin
            full  = 1;
            bdata = sample_data;
            xfer_cnt++;
         end
      end
   end

   function automatic void expect_now(output logic b, output logic lr, output logic d);
      int m, p, f, j;
      logic [BW-1:0] w;
      b = ((n / CD) % 2) == 1;
      m = n / HP;
      if (m == 0) begin
         lr = 1'b0;
         d  = 1'b0;
      end else begin
         p  = (m - 1) % FR;
         f  = ((m - 1) / FR) % 256;
         lr = ((p + 1) % FR) >= SW;
         w  = (p < SW || DUP) ? words[f] : '0;
         j  = p % SW;
         d  = (j < BW) ? w[BW-1-j] : 1'b0;
      end
   endfunction

   always @(negedge clk) begin
      logic eb, elr, ed;
      int m, p, f;
      if (rst_n) begin
         expect_now(eb, elr, ed);
         chk("BCLK", BCLK, eb);
         chk("LRCLK", LRCLK, elr);
         chk("DOUT", DOUT, ed);
         chk("underrun", underrun, exp_ur);
         chk("sample_ready", sample_ready, !full);
         if ((n % HP) == CD && (n / HP) >= 1) begin
            m = n / HP;
            p = (m - 1) % FR;
            f = ((m - 1) / FR) % 256;
            cap[f][FR-1-p] = DOUT;
         end
      end
   end

   // Hold valid with stable data until the model records the transfer.
   task automatic send(input logic [BW-1:0] d);
      int start;
      int guard;
      start        = xfer_cnt;
      sample_valid = 1'b1;
      sample_data  = d;
      guard        = 0;
      while (xfer_cnt == start && guard < 600) begin
         @(negedge clk);
         guard++;
      end
      checks++;
      if (xfer_cnt == start) begin
         failures++;
         $display("FAIL handshake_timeout actual=no_transfer required=transfer data=%h", d);
      end
   endtask

   typedef struct {
      logic [BW-1:0] sample;
      logic [31:0]   left_exp;
      logic [31:0]   right_dup;
   } vec_t;

   localparam int NT = 6;
   vec_t tbl [NT];

   initial begin
      int lim, guard, ur_cnt, gap;
      logic [31:0] right_req;
      tbl[0] = '{18'h2A5A5, 32'hA969_4000, 32'hA969_4000};
      tbl[1] = '{18'h20001, 32'h8000_4000, 32'h8000_4000};
      tbl[2] = '{18'h00001, 32'h0000_4000, 32'h0000_4000};
      tbl[3] = '{18'h00002, 32'h0000_8000, 32'h0000_8000};
      tbl[4] = '{18'h00003, 32'h0000_C000, 32'h0000_C000};
      tbl[5] = '{18'h3FFFF, 32'hFFFF_C000, 32'hFFFF_C000};

      clk          = 1'b0;
      rst_n        = 1'b0;
      sample_valid = 1'b0;
      sample_data  = '0;
      for (int i = 0; i < 256; i++) cap[i] = '0;

      repeat (3) @(negedge clk);
      chk("rst_BCLK", BCLK, 1'b0);
      chk("rst_LRCLK", LRCLK, 1'b0);
      chk("rst_DOUT", DOUT, 1'b0);
      chk("rst_underrun", underrun, 1'b0);
      chk("rst_sample_ready", sample_ready, 1'b1);
      rst_n = 1'b1;

      // Frame 0 underruns; table entry i lands in frame i+1.
      repeat (10) @(negedge clk);
      for (int i = 0; i < NT; i++) send(tbl[i].sample);
      sample_valid = 1'b0;

      lim   = HP * (FR * NT + FR) + CD;
      guard = 0;
      while (n <= lim && guard < 5000) begin
         @(negedge clk);
         guard++;
      end
      chk32("frame0_left", cap[0][63:32], 32'h0);
      chk32("frame0_right", cap[0][31:0], 32'h0);
      for (int i = 0; i < NT; i++) begin
         right_req = DUP ? tbl[i].right_dup : 32'h0;
         chk32("table_left", cap[i+1][63:32], tbl[i].left_exp);
         chk32("table_right", cap[i+1][31:0], right_req);
      end

      // Random data and gaps; one long gap guarantees a skipped frame.
      for (int i = 0; i < 10; i++) begin
         gap = (i == 3) ? 600 : int'($urandom_range(0, 300));
         repeat (gap) @(negedge clk);
         send(BW'($urandom));
         sample_valid = 1'b0;
      end

      // Second send transfers right after a frame load, so the buffer is full mid-left-slot.
      send(18'h3FFFF);
      send(18'h3FFFF);
      sample_valid = 1'b0;
      repeat (40) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("async_BCLK", BCLK, 1'b0);
      chk("async_LRCLK", LRCLK, 1'b0);
      chk("async_DOUT", DOUT, 1'b0);
      chk("async_underrun", underrun, 1'b0);
      chk("async_sample_ready", sample_ready, 1'b1);
      repeat (2) @(negedge clk);
      rst_n  = 1'b1;
      ur_cnt = 0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (underrun) ur_cnt++;
      end
      checks++;
      if (ur_cnt != 1) begin
         failures++;
         $display("FAIL post_reset_underrun_count actual=%0d required=1", ur_cnt);
      end
      chk32("post_reset_frame0", cap[0][63:32], 32'h0);
      repeat (300) @(negedge clk);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

`default_nettype wire
